mp3_pc_ram_arbiter: RTL and testbench
=====================================

Name: mp3_pc_ram_arbiter

Overview:
- Two-master arbiter sharing the single-port 4096x32 on-chip RAM: m0 is the Nios CPU data master, m1 is the MP3 frame DMA.
- Sits between both masters and the RAM slave; issues at most one access per cycle.
- Round-robin fairness with a bounded burst ownership window.
- Tracks the RAM's 1-cycle read latency and routes returned data to the issuing master.

Parameters:
ADDR_W, 12, word address width (4096 words)
DATA_W, 32, data width
BE_W, 4, byteenable width (DATA_W/8)
BURST_MAX, 8, max consecutive accesses granted to one master while the other waits (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
m0_address  in  ADDR_W  CPU word address
m0_byteenable  in  BE_W  CPU byte lanes
m0_read  in  1  CPU read request
m0_write  in  1  CPU write request
m0_writedata  in  DATA_W  CPU write data
m0_waitrequest  out  1  CPU stall
m0_readdata  out  DATA_W  CPU read data
m0_readdatavalid  out  1  CPU read data strobe
m1_address, m1_byteenable, m1_read, m1_write, m1_writedata  in  as m0  DMA request
m1_waitrequest, m1_readdata, m1_readdatavalid  out  as m0  DMA response
ram_address  out  ADDR_W  RAM address
ram_byteenable  out  BE_W  RAM byte lanes
ram_chipselect  out  1  RAM access this cycle
ram_write  out  1  RAM write strobe
ram_writedata  out  DATA_W  RAM write data
ram_clken  out  1  RAM clock enable, constant 1
ram_readdata  in  DATA_W  RAM data, valid 1 cycle after a read is issued

Behaviour:
- Request: reqX = mX_read | mX_write. read and write together are treated as a write.
- State machine: IDLE, OWN0, OWN1. Also burst counter cnt (0..BURST_MAX) and round-robin pointer rr (= master favoured on next tie).
- Grant (combinational from state and requests):
  - IDLE: lone requester wins; if both request, rr wins.
  - OWNx: x keeps the grant while reqx and (!req_other or cnt < BURST_MAX). Otherwise the grant passes to the other master in the same cycle if it requests.
- Accepted access: accX = reqX & grantX. mX_waitrequest = reqX & ~grantX. Never grant both masters; never stall a lone requester.
- RAM drive: ram_chipselect = acc0|acc1; ram_write = accepted write. ram_address, ram_byteenable and ram_writedata mux the granted master. When idle, drive the mux to m0 with chipselect 0.
- State update on each clk edge:
  - State = OWNx of the granted master, or IDLE if no access.
  - cnt = 1 on an ownership change; cnt+1 on continued ownership (saturates at BURST_MAX); 0 in IDLE.
  - rr = the non-granted master whenever both requested; otherwise unchanged.
- Read return: an accepted read sets registered rd_pend=1 and tag=x. The next cycle, mX_readdatavalid=1 for tag x only, and mX_readdata=ram_readdata.
- Read latency: 1 cycle, fully pipelined; back-to-back reads (same or alternating masters) each return exactly one cycle later.
- Writes produce no readdatavalid.
- Reset values: state IDLE, cnt 0, rr=m0, rd_pend 0, both readdatavalid 0, ram_chipselect 0, ram_write 0. Waitrequest follows requests combinationally.
- Reset asserted with a read pending: the pending read is discarded and no readdatavalid is issued after reset release.
- BURST_MAX=1 degenerates to strict alternation under contention.

Test Plan:
- Reset then m0 write addr 0x010 data 0xDEADBEEF be 0xF, then m0 read 0x010 -> write accepted with no wait; m0_readdatavalid exactly 1 cycle after the read with 0xDEADBEEF; m1 outputs idle.
- m1 continuous reads 0x100..0x10F while m0 requests a read from cycle 2 -> m1 gets exactly 8 consecutive grants, then m0 is granted; m0_waitrequest is high for the intervening cycles; m1 resumes after.
- Both request in the same cycle from IDLE after reset -> m0 wins; next tie from IDLE -> m1 wins (rr alternates).
- Alternating single-cycle reads m0@0x001, m1@0x002, m0@0x003 -> each readdatavalid on the correct master 1 cycle later with correct data; no cross-routing.
- m1 write be=0x3 data 0x12345678 over existing 0xAAAAAAAA at 0x200, then read -> returns 0xAAAA5678.
- Reset pulsed the cycle after an accepted m0 read -> no m0_readdatavalid after release; state IDLE; rr=m0.

Source files
------------

// File: rtl/mp3_pc_ram_arbiter.sv
// Two-master round-robin arbiter in front of the single-port on-chip RAM.
// CPU data master (m0) and MP3 frame DMA (m1) share the RAM; each ownership is limited to a bounded burst.
module mp3_pc_ram_arbiter #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BE_W      = 4,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_q, rr_d;        // 0: m0 favoured on next tie, 1: m1
  logic             rd_pend_q, rd_pend_d;
  logic             tag_q, tag_d;

  logic req0, req1;
  logic grant0, grant1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grants are suppressed while reset is held so the RAM sees no access.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (req0 && req1) begin
            grant0 = ~rr_q;
            grant1 = rr_q;
          end else begin
            grant0 = req0;
            grant1 = req1;
          end
        end
        OWN0: begin
          if (req0 && (!req1 || cnt_q < CNT_MAX)) grant0 = 1'b1;
          else                                    grant1 = req1;
        end
        OWN1: begin
          if (req1 && (!req0 || cnt_q < CNT_MAX)) grant1 = 1'b1;
          else                                    grant0 = req0;
        end
        default: begin
          grant0 = req0;
          grant1 = req1 & ~req0;
        end
      endcase
    end
  end

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  assign ram_chipselect = grant0 | grant1;
  assign ram_write      = (grant0 & m0_write) | (grant1 & m1_write);
  assign ram_address    = grant1 ? m1_address    : m0_address;
  assign ram_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = grant1 ? m1_writedata  : m0_writedata;
  assign ram_clken      = 1'b1;

  always_comb begin
    state_d   = IDLE;
    cnt_d     = '0;
    rr_d      = rr_q;
    rd_pend_d = 1'b0;
    tag_d     = tag_q;
    if (grant0 || grant1) begin
      state_d = grant0 ? OWN0 : OWN1;
      if ((grant0 && state_q == OWN0) || (grant1 && state_q == OWN1))
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      else
        cnt_d = CNT_W'(1);
      rd_pend_d = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);
      tag_d     = grant1;
    end
    if (req0 && req1 && (grant0 || grant1)) rr_d = grant0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      tag_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      rd_pend_q <= rd_pend_d;
      tag_q     <= tag_d;
    end
  end

  assign m0_readdatavalid = rd_pend_q & ~tag_q;
  assign m1_readdatavalid = rd_pend_q & tag_q;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_mp3_pc_ram_arbiter.sv
// Directed bench for mp3_pc_ram_arbiter with a behavioural 4096x32 RAM slave.
module tb_mp3_pc_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [11:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  mp3_pc_ram_arbiter #(.ADDR_W(12), .DATA_W(32), .BE_W(4), .BURST_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_address = '0; m0_byteenable = 4'hF; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
    m1_address = '0; m1_byteenable = 4'hF; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
  endtask

  task automatic wr0(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    idle_inputs();
    m0_write = 1'b1; m0_address = a; m0_writedata = d;
    @(negedge clk);
    idle_inputs();
  endtask

  int unsigned j;
  logic        m0_done, pv0, pv1;
  logic [31:0] pd;

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m0_rdv", m0_readdatavalid, 0);
    chk("rst_m1_rdv", m1_readdatavalid, 0);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_write", ram_write, 0);
    chk("clken", ram_clken, 1);

    // m0 write then read back
    @(negedge clk);
    reset = 1'b0;
    m0_write = 1'b1; m0_address = 12'h010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    #1;
    chk("t1_wr_wait", m0_waitrequest, 0);
    chk("t1_wr_cs", ram_chipselect, 1);
    chk("t1_wr_we", ram_write, 1);
    chk("t1_wr_addr", ram_address, 32'h010);
    chk("t1_wr_data", ram_writedata, 32'hDEADBEEF);
    @(negedge clk);
    m0_write = 1'b0; m0_read = 1'b1;
    #1;
    chk("t1_rd_wait", m0_waitrequest, 0);
    chk("t1_rd_we", ram_write, 0);
    chk("t1_wr_no_rdv", m0_readdatavalid, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("t1_rdv", m0_readdatavalid, 1);
    chk("t1_rdata", m0_readdata, 32'hDEADBEEF);
    chk("t1_m1_rdv", m1_readdatavalid, 0);
    chk("t1_m1_wait", m1_waitrequest, 0);
    @(negedge clk);
    #1;
    chk("t1_rdv_once", m0_readdatavalid, 0);

    // burst window: m1 streams 16 reads, m0 joins at cycle 1
    for (int i = 0; i < 16; i++) wr0(12'h100 + 12'(i), 32'hA5000100 + 32'(i));
    wr0(12'h020, 32'h0000C0DE);
    j = 0; m0_done = 1'b0; pv0 = 1'b0; pv1 = 1'b0; pd = '0;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      m1_read = (j < 16); m1_address = 12'h100 + 12'(j);
      m0_read = (k >= 1) && !m0_done; m0_address = 12'h020;
      #1;
      chk($sformatf("burst_m0_wait_k%0d", k), m0_waitrequest, (k >= 1 && k <= 7));
      chk($sformatf("burst_m1_wait_k%0d", k), m1_waitrequest, (k == 8));
      chk($sformatf("burst_m1_rdv_k%0d", k), m1_readdatavalid, pv1);
      chk($sformatf("burst_m0_rdv_k%0d", k), m0_readdatavalid, pv0);
      if (pv1) chk($sformatf("burst_m1_data_k%0d", k), m1_readdata, pd);
      if (pv0) chk($sformatf("burst_m0_data_k%0d", k), m0_readdata, 32'h0000C0DE);
      pv1 = (k != 8); pv0 = (k == 8); pd = 32'hA5000100 + 32'(j);
      if (k == 8) m0_done = 1'b1;
      else        j++;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("burst_last_rdv", m1_readdatavalid, 1);
    chk("burst_last_data", m1_readdata, 32'hA500010F);

    // round-robin ties from IDLE after reset
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    m0_write = 1'b1; m0_address = 12'h300; m0_writedata = 32'h1;
    m1_write = 1'b1; m1_address = 12'h301; m1_writedata = 32'h2;
    #1;
    chk("tie1_m0_wait", m0_waitrequest, 0);
    chk("tie1_m1_wait", m1_waitrequest, 1);
    chk("tie1_addr", ram_address, 32'h300);
    @(negedge clk);
    m0_write = 1'b0;
    #1;
    chk("tie1_m1_next", m1_waitrequest, 0);
    chk("tie1_m1_addr", ram_address, 32'h301);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    m0_write = 1'b1; m0_address = 12'h300;
    m1_write = 1'b1; m1_address = 12'h301;
    #1;
    chk("tie2_m1_wait", m1_waitrequest, 0);
    chk("tie2_m0_wait", m0_waitrequest, 1);
    chk("tie2_addr", ram_address, 32'h301);
    @(negedge clk);
    m1_write = 1'b0;
    #1;
    chk("tie2_m0_next", m0_waitrequest, 0);
    @(negedge clk);
    idle_inputs();

    // alternating single reads, no cross-routing
    wr0(12'h001, 32'h11111111);
    wr0(12'h002, 32'h22222222);
    wr0(12'h003, 32'h33333333);
    @(negedge clk);
    m0_read = 1'b1; m0_address = 12'h001;
    #1;
    chk("alt_m0_wait", m0_waitrequest, 0);
    @(negedge clk);
    idle_inputs(); m1_read = 1'b1; m1_address = 12'h002;
    #1;
    chk("alt1_m0_rdv", m0_readdatavalid, 1);
    chk("alt1_m0_data", m0_readdata, 32'h11111111);
    chk("alt1_m1_rdv", m1_readdatavalid, 0);
    chk("alt1_m1_wait", m1_waitrequest, 0);
    @(negedge clk);
    idle_inputs(); m0_read = 1'b1; m0_address = 12'h003;
    #1;
    chk("alt2_m1_rdv", m1_readdatavalid, 1);
    chk("alt2_m1_data", m1_readdata, 32'h22222222);
    chk("alt2_m0_rdv", m0_readdatavalid, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("alt3_m0_rdv", m0_readdatavalid, 1);
    chk("alt3_m0_data", m0_readdata, 32'h33333333);
    chk("alt3_m1_rdv", m1_readdatavalid, 0);

    // partial byte-lane write by m1
    wr0(12'h200, 32'hAAAAAAAA);
    @(negedge clk);
    m1_write = 1'b1; m1_address = 12'h200; m1_writedata = 32'h12345678; m1_byteenable = 4'h3;
    #1;
    chk("be_wait", m1_waitrequest, 0);
    chk("be_lanes", ram_byteenable, 32'h3);
    @(negedge clk);
    idle_inputs(); m1_read = 1'b1; m1_address = 12'h200;
    #1;
    chk("be_no_rdv", m1_readdatavalid, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("be_rdv", m1_readdatavalid, 1);
    chk("be_data", m1_readdata, 32'hAAAA5678);

    // reset with a read pending
    @(negedge clk);
    m0_read = 1'b1; m0_address = 12'h010;
    #1;
    chk("rp_cs", ram_chipselect, 1);
    @(negedge clk);
    idle_inputs(); reset = 1'b1;
    #1;
    chk("rp_rdv_in_reset", m0_readdatavalid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rp_rdv_after", m0_readdatavalid, 0);
    chk("rp_cs_after", ram_chipselect, 0);
    @(negedge clk);
    m0_read = 1'b1; m0_address = 12'h010;
    m1_read = 1'b1; m1_address = 12'h020;
    #1;
    chk("rp_tie_m0_wait", m0_waitrequest, 0);
    chk("rp_tie_m1_wait", m1_waitrequest, 1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rp_post_rdv", m0_readdatavalid, 1);
    chk("rp_post_data", m0_readdata, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
